spi_reg_controller: RTL and testbench

//  SPI mode-0 controller that issues 16-bit register-access frames to the onboarding SPI peripheral
//  (bit15 = R/W, 1 = write; bits14:8 = address; bits7:0 = data; MSB first; nCS active-low).

---
 rtl/spi_reg_controller.sv | 191 +++++++++++++++++++
 tb/tb_spi_reg_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_controller.sv
// SPI mode-0 controller issuing 16-bit register frames {rw, addr[6:0], data[7:0]}, MSB first.
// Optional read-data capture from CIPO is enabled with `define SPI_CIPO_RX_EN.
module spi_reg_controller #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  input  logic       cipo,
  output logic       done,
  output logic [7:0] rsp_data,
  output logic       rsp_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [15:0] frame_q, frame_d;
  logic        rw_q, rw_d;
  logic        done_q, done_d;
  logic        ready_c;
  logic        tick;
  logic        sample_en;
  logic        frame_end;

  assign tick      = (cnt_q == 8'd0);
  assign cmd_ready = ready_c & ~rst;
  assign done      = done_q;

  // phase_q: 0 = SCLK-high half of the current bit, 1 = SCLK-low half.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    frame_d   = frame_q;
    rw_d      = rw_q;
    done_d    = 1'b0;
    ready_c   = 1'b0;
    sclk      = 1'b0;
    copi      = 1'b0;
    ncs       = 1'b1;
    sample_en = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (cmd_valid) begin
          state_d = S_SETUP;
          cnt_d   = DIV_LD;
          frame_d = {cmd_rw, cmd_addr, cmd_rw ? cmd_data : 8'h00};
          rw_d    = cmd_rw;
        end
      end
      S_SETUP: begin
        ncs  = 1'b0;
        copi = frame_q[15];
        if (tick) begin
          state_d = S_SHIFT;
          cnt_d   = DIV_LD;
          bit_d   = 4'd0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SHIFT: begin
        ncs  = 1'b0;
        sclk = ~phase_q;
        copi = frame_q[15];
        if (tick) begin
          cnt_d = DIV_LD;
          if (!phase_q) begin
            // End of the high half: sample CIPO, then SCLK falls and COPI advances,
            // except after the last bit so COPI keeps bit0 through HOLD.
            phase_d   = 1'b1;
            sample_en = 1'b1;
            if (bit_q != 4'd15) frame_d = {frame_q[14:0], 1'b0};
          end else if (bit_q == 4'd15) begin
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q + 4'd1;
            phase_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        ncs  = 1'b0;
        copi = frame_q[15];
        if (tick) begin
          done_d    = 1'b1;
          frame_end = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (tick) state_d = S_IDLE;
        else      cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      phase_q <= 1'b0;
      frame_q <= 16'h0000;
      rw_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      rw_q    <= rw_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_CIPO_RX_EN
  logic [7:0] rx_q, rx_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_valid_q, rsp_valid_d;

  // CIPO is stable for the whole high half in mode 0; sampling at its end covers bits 8..15.
  always_comb begin
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    if (sample_en && bit_q[3] && !rw_q) rx_d = {rx_q[6:0], cipo};
    if (frame_end && !rw_q) begin
      rsp_data_d  = rx_q;
      rsp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q        <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
    end else begin
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
`else
  logic unused_rx;
  assign unused_rx = cipo ^ sample_en ^ frame_end;
  assign rsp_data  = 8'h00;
  assign rsp_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench for spi_reg_controller: a default instance (CLK_DIV=2, GAP_CYCLES=4)
// and a fast instance (CLK_DIV=1, GAP_CYCLES=0), both watched by a wire-level monitor.
module tb_spi_reg_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       sclk, copi, ncs, cipo, done, rsp_valid;
  logic [7:0] rsp_data;

  logic       cmd_valid_f, cmd_ready_f, cmd_rw_f;
  logic [6:0] cmd_addr_f;
  logic [7:0] cmd_data_f;
  logic       sclk_f, copi_f, ncs_f, done_f, rsp_valid_f;
  logic       cipo_f = 1'b0;
  logic [7:0] rsp_data_f;

  spi_reg_controller #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .done(done), .rsp_data(rsp_data), .rsp_valid(rsp_valid));

  spi_reg_controller #(.CLK_DIV(1), .GAP_CYCLES(0)) dut_fast (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_f), .cmd_ready(cmd_ready_f), .cmd_rw(cmd_rw_f),
    .cmd_addr(cmd_addr_f), .cmd_data(cmd_data_f), .sclk(sclk_f), .copi(copi_f), .ncs(ncs_f),
    .cipo(cipo_f), .done(done_f), .rsp_data(rsp_data_f), .rsp_valid(rsp_valid_f));

`ifdef SPI_CIPO_RX_EN
  localparam logic [7:0] EXP_RSP  = 8'hA5;
  localparam int         EXP_RSPV = 1;
`else
  localparam logic [7:0] EXP_RSP  = 8'h00;
  localparam int         EXP_RSPV = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Wire monitor, one slot per instance (0 = default, 1 = fast).
  logic [1:0]  m_sclk, m_ncs, m_copi, m_done;
  assign m_sclk = {sclk_f, sclk};
  assign m_ncs  = {ncs_f, ncs};
  assign m_copi = {copi_f, copi};
  assign m_done = {done_f, done};

  int cyc[2]        = '{0, 0};
  int low_run[2]    = '{0, 0};
  int last_low[2]   = '{0, 0};
  int rises[2]      = '{0, 0};
  int last_rises[2] = '{0, 0};
  int falls[2]      = '{0, 0};
  int rise_cyc[2]   = '{0, 0};
  int per_min[2]    = '{0, 0};
  int per_max[2]    = '{0, 0};
  int last_pmin[2]  = '{0, 0};
  int last_pmax[2]  = '{0, 0};
  int ncs_rise[2]   = '{0, 0};
  int last_gap[2]   = '{0, 0};
  int done_total[2] = '{0, 0};
  int idle_viol[2]  = '{0, 0};
  logic [15:0] word[2]      = '{16'h0, 16'h0};
  logic [15:0] last_word[2] = '{16'h0, 16'h0};
  logic prev_sclk[2] = '{1'b0, 1'b0};
  logic prev_ncs[2]  = '{1'b1, 1'b1};
  int rspv_total = 0;
  int rspv_bad   = 0;
  logic [7:0] resp_byte = 8'h00;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cyc[i]++;
      if (m_done[i] === 1'b1) done_total[i]++;
      if (m_ncs[i] === 1'b1 && m_sclk[i] === 1'b1) idle_viol[i]++;
      if (m_ncs[i] === 1'b0) begin
        if (prev_ncs[i]) begin
          last_gap[i] = cyc[i] - ncs_rise[i];
          low_run[i] = 0; rises[i] = 0; falls[i] = 0; per_min[i] = 1000; per_max[i] = 0;
        end
        low_run[i]++;
        if (m_sclk[i] && !prev_sclk[i]) begin
          word[i] = {word[i][14:0], m_copi[i]};
          if (rises[i] > 0) begin
            if (cyc[i] - rise_cyc[i] < per_min[i]) per_min[i] = cyc[i] - rise_cyc[i];
            if (cyc[i] - rise_cyc[i] > per_max[i]) per_max[i] = cyc[i] - rise_cyc[i];
          end
          rise_cyc[i] = cyc[i];
          rises[i]++;
        end
        if (!m_sclk[i] && prev_sclk[i]) falls[i]++;
      end else if (!prev_ncs[i]) begin
        last_low[i] = low_run[i]; last_rises[i] = rises[i]; last_word[i] = word[i];
        last_pmin[i] = per_min[i]; last_pmax[i] = per_max[i]; ncs_rise[i] = cyc[i];
      end
      prev_sclk[i] = m_sclk[i];
      prev_ncs[i]  = m_ncs[i];
    end
    if (rsp_valid === 1'b1) rspv_total++;
    if (rsp_valid === 1'b1 && done !== 1'b1) rspv_bad++;
  end

  // Peripheral model: presents resp_byte MSB first, changing after SCLK falls 8..15.
  always_comb begin
    cipo = 1'b0;
    if (falls[0] >= 8 && falls[0] < 16) cipo = resp_byte[3'(15 - falls[0])];
  end

  // Presents a command to the default instance and returns just after the accepting edge.
  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d, input bit hold);
    bit ok = 1'b0;
    cmd_rw = rw; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL accept: cmd_ready never seen, required 1"); end
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // One frame on the default instance; lat = cycles from accept to the next ready.
  task automatic run_frame(input logic rw, input logic [6:0] a, input logic [7:0] d, output int lat);
    send(rw, a, d, 1'b0);
    lat = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); lat++;
      if (cmd_ready) break;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h55; cmd_data = 8'h66;
    cmd_valid_f = 1'b1; cmd_rw_f = 1'b1; cmd_addr_f = 7'h11; cmd_data_f = 8'h22;
    repeat (4) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", cmd_ready); end
    n_checks++; if (ncs !== 1'b1) begin n_fail++; $display("FAIL rst_ncs: got %b required 1", ncs); end
    n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b required 0", sclk); end
    n_checks++; if (copi !== 1'b0) begin n_fail++; $display("FAIL rst_copi: got %b required 0", copi); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data: got %h required 00", rsp_data); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    n_checks++; if (cmd_ready_f !== 1'b0) begin n_fail++; $display("FAIL rst_ready_fast: got %b required 0", cmd_ready_f); end
    cmd_valid = 1'b0; cmd_valid_f = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b required 1", cmd_ready); end
    n_checks++; if (ncs !== 1'b1) begin n_fail++; $display("FAIL rel_ncs: got %b required 1", ncs); end
    n_checks++; if (done_total[0] !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d required 0", done_total[0]); end
  endtask

  task automatic test_write_basic();
    int d0 = done_total[0];
    int lat;
    run_frame(1'b1, 7'h00, 8'hFF, lat);
    n_checks++; if (last_word[0] !== 16'h80FF) begin n_fail++; $display("FAIL wr1_word: got %h required 80ff", last_word[0]); end
    n_checks++; if (last_low[0] !== 68) begin n_fail++; $display("FAIL wr1_ncs_low: got %0d required 68", last_low[0]); end
    n_checks++; if (done_total[0] - d0 !== 1) begin n_fail++; $display("FAIL wr1_done: got %0d pulses required 1", done_total[0] - d0); end
  endtask

  task automatic test_write_edges();
    int lat;
    run_frame(1'b1, 7'h04, 8'h80, lat);
    n_checks++; if (last_word[0] !== 16'h8480) begin n_fail++; $display("FAIL wr2_word: got %h required 8480", last_word[0]); end
    n_checks++; if (last_rises[0] !== 16) begin n_fail++; $display("FAIL wr2_rises: got %0d required 16", last_rises[0]); end
    n_checks++; if (idle_viol[0] !== 0) begin n_fail++; $display("FAIL wr2_sclk_idle: got %0d violations required 0", idle_viol[0]); end
    n_checks++; if (lat !== 73) begin n_fail++; $display("FAIL wr2_latency: got %0d required 73", lat); end
  endtask

  task automatic test_read();
    int r0 = rspv_total;
    int lat;
    resp_byte = 8'hA5;
    run_frame(1'b0, 7'h02, 8'h5C, lat);
    n_checks++; if (last_word[0] !== 16'h0200) begin n_fail++; $display("FAIL rd_word: got %h required 0200", last_word[0]); end
    n_checks++; if (rsp_data !== EXP_RSP) begin n_fail++; $display("FAIL rd_rsp_data: got %h required %h", rsp_data, EXP_RSP); end
    n_checks++; if (rspv_total - r0 !== EXP_RSPV) begin n_fail++; $display("FAIL rd_rsp_valid: got %0d pulses required %0d", rspv_total - r0, EXP_RSPV); end
    n_checks++; if (rspv_bad !== 0) begin n_fail++; $display("FAIL rd_rsp_with_done: got %0d stray pulses required 0", rspv_bad); end
    resp_byte = 8'h3C;
    run_frame(1'b1, 7'h10, 8'h01, lat);
    n_checks++; if (rsp_data !== EXP_RSP) begin n_fail++; $display("FAIL rd_hold_after_wr: got %h required %h", rsp_data, EXP_RSP); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1 = 16'h0;
    bit ok = 1'b0;
    send(1'b1, 7'h11, 8'h22, 1'b1);
    repeat (6) @(negedge clk);
    cmd_rw = 1'b0; cmd_addr = 7'h7F; cmd_data = 8'h00;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h33; cmd_data = 8'h44;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    w1 = last_word[0];
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    @(negedge clk);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_ready: cmd_ready never seen, required 1"); end
    n_checks++; if (w1 !== 16'h9122) begin n_fail++; $display("FAIL b2b_word1: got %h required 9122", w1); end
    n_checks++; if (last_word[0] !== 16'hB344) begin n_fail++; $display("FAIL b2b_word2: got %h required b344", last_word[0]); end
    n_checks++; if (last_gap[0] !== 5) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles required 5", last_gap[0]); end
  endtask

  task automatic test_reset_mid();
    int d0;
    int lat;
    bit ok = 1'b0;
    send(1'b1, 7'h55, 8'hAA, 1'b0);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rises[0] == 8) begin ok = 1'b1; break; end
    end
    d0 = done_total[0];
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_reach_bit7: not reached, required reach"); end
    n_checks++; if (ncs !== 1'b1) begin n_fail++; $display("FAIL mid_ncs: got %b required 1", ncs); end
    n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL mid_sclk: got %b required 0", sclk); end
    n_checks++; if (copi !== 1'b0) begin n_fail++; $display("FAIL mid_copi: got %b required 0", copi); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b required 0", done); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (done_total[0] !== d0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses required 0", done_total[0] - d0); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b required 0", rsp_valid); end
    run_frame(1'b1, 7'h1A, 8'h3C, lat);
    n_checks++; if (last_word[0] !== 16'h9A3C) begin n_fail++; $display("FAIL mid_fresh_word: got %h required 9a3c", last_word[0]); end
    n_checks++; if (last_rises[0] !== 16) begin n_fail++; $display("FAIL mid_fresh_rises: got %0d required 16", last_rises[0]); end
    n_checks++; if (lat !== 73) begin n_fail++; $display("FAIL mid_fresh_latency: got %0d required 73", lat); end
  endtask

  task automatic test_fast();
    int d0 = done_total[1];
    int lat = 0;
    bit ok = 1'b0;
    cmd_rw_f = 1'b1; cmd_addr_f = 7'h5A; cmd_data_f = 8'hC3; cmd_valid_f = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (cmd_ready_f) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1 cmd_valid_f = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); lat++;
      if (cmd_ready_f) break;
    end
    @(negedge clk);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fast_accept: cmd_ready never seen, required 1"); end
    n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL fast_latency: got %0d required 35", lat); end
    n_checks++; if (last_low[1] !== 34) begin n_fail++; $display("FAIL fast_ncs_low: got %0d required 34", last_low[1]); end
    n_checks++; if (last_word[1] !== 16'hDAC3) begin n_fail++; $display("FAIL fast_word: got %h required dac3", last_word[1]); end
    n_checks++; if (last_rises[1] !== 16) begin n_fail++; $display("FAIL fast_rises: got %0d required 16", last_rises[1]); end
    n_checks++; if (last_pmin[1] !== 2 || last_pmax[1] !== 2) begin n_fail++; $display("FAIL fast_sclk_period: got %0d..%0d required 2", last_pmin[1], last_pmax[1]); end
    n_checks++; if (done_total[1] - d0 !== 1) begin n_fail++; $display("FAIL fast_done: got %0d pulses required 1", done_total[1] - d0); end
    n_checks++; if (idle_viol[1] !== 0) begin n_fail++; $display("FAIL fast_sclk_idle: got %0d violations required 0", idle_viol[1]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 7'h00; cmd_data = 8'h00;
    cmd_valid_f = 1'b0; cmd_rw_f = 1'b0; cmd_addr_f = 7'h00; cmd_data_f = 8'h00;
    test_reset();
    test_write_basic();
    test_write_edges();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_fast();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
